// File: rtl/jvm_byte_fetcher_pkg.sv
// Shared definitions for the JVM byte fetcher and the translator FSM that drives it.
// Fetch-state encodings are fixed so the translator and debug tooling agree on them.
package jvm_byte_fetcher_pkg;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t FETCH_IDLE     = 2'd0;
   localparam fetch_state_t FETCH_MEM_REQ  = 2'd1;
   localparam fetch_state_t FETCH_MEM_WAIT = 2'd2;

   localparam int unsigned BYTES_PER_WORD = 4;

   // WIDE prefix opcode; the translator needs two extra operand bytes after it.
   localparam logic [7:0] OP_WIDE = 8'hC4;

endpackage

// File: rtl/jvm_byte_fetcher_byte_lane_sel.sv
// Big-endian byte extraction: lane 0 is the most significant byte of the word.
module jvm_byte_fetcher_byte_lane_sel (
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   output logic [7:0]  lane_byte
);

   always_comb begin
      lane_byte = word[31:24];
      case (lane)
         2'd0:    lane_byte = word[31:24];
         2'd1:    lane_byte = word[23:16];
         2'd2:    lane_byte = word[15:8];
         default: lane_byte = word[7:0];
      endcase
   end

endmodule

// File: rtl/jvm_byte_fetcher.sv
// Responder for the translator's byte-fetch handshake: one ready pulse per accepted start,
// served from a one-word cache or from a two-edge bytecode RAM read.
module jvm_byte_fetcher
   import jvm_byte_fetcher_pkg::*;
#(
   parameter int SIZE          = 1024,
   parameter int ADDRESS_WIDTH = 10
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       pc_reset,
   input  logic                       pc_load,
   input  logic [ADDRESS_WIDTH+1:0]   pc_load_val,
   input  logic                       start,
   output logic                       ready,
   output logic [7:0]                 next_byte,
   output logic [ADDRESS_WIDTH+1:0]   pc,
   output logic                       mem_rd_en,
   output logic [ADDRESS_WIDTH-1:0]   mem_addr,
   input  logic [31:0]                mem_rdata,
   output fetch_state_t               state
);

   localparam int          PCW       = ADDRESS_WIDTH + 2;
   localparam int unsigned PC_SPAN   = BYTES_PER_WORD * SIZE;
   localparam int unsigned FULL_SPAN = 32'd1 << PCW;
   localparam logic [PCW-1:0] LAST_PC = PCW'(PC_SPAN - 1);

   logic [31:0]              cache_word;
   logic [ADDRESS_WIDTH-1:0] cache_tag;
   logic                     cache_valid;

   logic [ADDRESS_WIDTH-1:0] pc_word;
   logic                     cache_hit;
   logic [PCW-1:0]           pc_inc;
   logic [PCW-1:0]           pc_load_mod;
   logic [31:0]              lane_word;
   logic [7:0]               lane_byte;

   assign pc_word   = pc[PCW-1:2];
   assign cache_hit = cache_valid && (cache_tag == pc_word);
   assign pc_inc    = (pc == LAST_PC) ? '0 : pc + PCW'(1);

   // The returning RAM word is used directly in MEM_WAIT; otherwise the cached word.
   assign lane_word = (state == FETCH_MEM_WAIT) ? mem_rdata : cache_word;

   // Branch targets beyond the RAM fold back into range; free when the span fills the PC.
   generate
      if (PC_SPAN == FULL_SPAN) begin : g_load_direct
         assign pc_load_mod = pc_load_val;
      end else begin : g_load_mod
         assign pc_load_mod = PCW'(32'(pc_load_val) % PC_SPAN);
      end
   endgenerate

   jvm_byte_fetcher_byte_lane_sel u_lane_sel (
      .word      (lane_word),
      .lane      (pc[1:0]),
      .lane_byte (lane_byte)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= FETCH_IDLE;
         ready       <= 1'b0;
         next_byte   <= 8'h00;
         pc          <= '0;
         mem_rd_en   <= 1'b0;
         mem_addr    <= '0;
         cache_word  <= 32'h0;
         cache_tag   <= '0;
         cache_valid <= 1'b0;
      end else begin
         ready <= 1'b0;
         // PC rewrites abort any fetch in flight; the RAM word arriving later is ignored.
         if (pc_reset) begin
            pc        <= '0;
            state     <= FETCH_IDLE;
            mem_rd_en <= 1'b0;
         end else if (pc_load) begin
            pc        <= pc_load_mod;
            state     <= FETCH_IDLE;
            mem_rd_en <= 1'b0;
         end else begin
            case (state)
               FETCH_IDLE: begin
                  if (start) begin
                     if (cache_hit) begin
                        ready     <= 1'b1;
                        next_byte <= lane_byte;
                        pc        <= pc_inc;
                     end else begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= pc_word;
                        state     <= FETCH_MEM_REQ;
                     end
                  end
               end
               FETCH_MEM_REQ: begin
                  mem_rd_en <= 1'b0;
                  state     <= FETCH_MEM_WAIT;
               end
               FETCH_MEM_WAIT: begin
                  cache_word  <= mem_rdata;
                  cache_tag   <= mem_addr;
                  cache_valid <= 1'b1;
                  ready       <= 1'b1;
                  next_byte   <= lane_byte;
                  pc          <= pc_inc;
                  state       <= FETCH_IDLE;
               end
               default: begin
                  mem_rd_en <= 1'b0;
                  state     <= FETCH_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jvm_byte_fetcher.sv
// Randomized bench for jvm_byte_fetcher against a "last word fetched" reference model.
module tb_jvm_byte_fetcher;
   import jvm_byte_fetcher_pkg::*;

   localparam int SIZE = 4;
   localparam int AW   = 3;
   localparam int PCW  = AW + 2;
   localparam int SPAN = 4 * SIZE;

   logic            clk;
   logic            rst_n;
   logic            pc_reset;
   logic            pc_load;
   logic [PCW-1:0]  pc_load_val;
   logic            start;
   logic            ready;
   logic [7:0]      next_byte;
   logic [PCW-1:0]  pc;
   logic            mem_rd_en;
   logic [AW-1:0]   mem_addr;
   logic [31:0]     mem_rdata;
   fetch_state_t    state;

   jvm_byte_fetcher #(.SIZE(SIZE), .ADDRESS_WIDTH(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc_reset    (pc_reset),
      .pc_load     (pc_load),
      .pc_load_val (pc_load_val),
      .start       (start),
      .ready       (ready),
      .next_byte   (next_byte),
      .pc          (pc),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .state       (state)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // bytecode RAM: data valid the cycle after the edge that samples mem_rd_en
   logic [31:0] ram [0:(1<<AW)-1];
   always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

   // reference model: byte PC plus the last word fully fetched
   int          m_pc;
   bit          m_valid;
   int          m_tag;
   logic [31:0] m_word;
   logic [7:0]  exp_q[$];

   int n_checks;
   int n_fail;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] be_byte(input logic [31:0] w, input int lane);
      logic [31:0] s;
      s = w >> (8 * (3 - lane));
      return s[7:0];
   endfunction

   function automatic bit model_hit();
      return m_valid && (m_tag == m_pc / 4);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_pc    = 0;
      m_valid = 1'b0;
      m_tag   = 0;
      m_word  = 32'h0;
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_ready"},     ready,     0);
      check({pfx, "_next_byte"}, next_byte, 0);
      check({pfx, "_pc"},        pc,        0);
      check({pfx, "_rd_en"},     mem_rd_en, 0);
      check({pfx, "_addr"},      mem_addr,  0);
      check({pfx, "_state"},     state,     FETCH_IDLE);
   endtask

   // driver: one full fetch, checking the exact cycle of each handshake event
   task automatic fetch(input bit busy_start);
      int          idx;
      bit          hit;
      logic [31:0] w;
      idx = m_pc / 4;
      hit = model_hit();
      w   = hit ? m_word : ram[idx];
      exp_q.push_back(be_byte(w, m_pc % 4));
      start = 1'b1;
      tick();
      start = 1'b0;
      if (hit) begin
         check("hit_rd_en", mem_rd_en, 0);
      end else begin
         check("miss_early_ready", ready, 0);
         check("miss_rd_en", mem_rd_en, 1);
         check("miss_addr", mem_addr, idx);
         if (busy_start) start = 1'b1;
         tick();
         start = 1'b0;
         check("req_ready", ready, 0);
         check("req_rd_en", mem_rd_en, 0);
         tick();
         m_valid = 1'b1;
         m_tag   = idx;
         m_word  = w;
      end
      m_pc = (m_pc + 1) % SPAN;
      check("ready", ready, 1);
      check("next_byte", next_byte, exp_q.pop_front());
      check("pc", pc, m_pc);
      tick();
      check("ready_pulse", ready, 0);
      check("after_rd_en", mem_rd_en, 0);
      check("after_state", state, FETCH_IDLE);
   endtask

   task automatic load(input int val, input bit with_start);
      pc_load_val = val[PCW-1:0];
      pc_load     = 1'b1;
      start       = with_start;
      tick();
      pc_load = 1'b0;
      start   = 1'b0;
      m_pc = val % SPAN;
      check("load_pc", pc, m_pc);
      check("load_ready", ready, 0);
      check("load_rd_en", mem_rd_en, 0);
   endtask

   task automatic do_pc_reset(input bit with_load);
      pc_reset    = 1'b1;
      pc_load     = with_load;
      pc_load_val = PCW'($urandom_range(1, SPAN - 1));
      start       = 1'b1;
      tick();
      pc_reset = 1'b0;
      pc_load  = 1'b0;
      start    = 1'b0;
      m_pc = 0;
      check("pcrst_pc", pc, 0);
      check("pcrst_ready", ready, 0);
      check("pcrst_rd_en", mem_rd_en, 0);
   endtask

   // caller guarantees a miss; abort in MEM_REQ (late=0) or MEM_WAIT (late=1)
   task automatic abort(input bit late, input bit use_load, input int val);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("abort_rd_en", mem_rd_en, 1);
      if (late) tick();
      if (use_load) begin
         pc_load_val = val[PCW-1:0];
         pc_load     = 1'b1;
         m_pc        = val % SPAN;
      end else begin
         pc_reset = 1'b1;
         m_pc     = 0;
      end
      start = $urandom_range(0, 1);
      tick();
      pc_load  = 1'b0;
      pc_reset = 1'b0;
      start    = 1'b0;
      check("abort_ready", ready, 0);
      check("abort_rd_en_off", mem_rd_en, 0);
      check("abort_state", state, FETCH_IDLE);
      check("abort_pc", pc, m_pc);
      tick();
      check("abort_no_late_ready", ready, 0);
      check("abort_no_refetch", mem_rd_en, 0);
   endtask

   // caller guarantees a miss; rst_n lands while the RAM word is on its way back
   task automatic reset_mid_fetch();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      check_reset_values("rst_mid");
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      pc_reset    = 1'b0;
      pc_load     = 1'b0;
      pc_load_val = '0;
      start       = 1'b0;
      mem_rdata   = 32'h0;
      for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
      ram[0] = 32'hC415_0360;
      ram[1] = 32'hAC00_0000;
      ram[2] = $urandom;
      ram[3] = 32'h0000_00B1;
      model_reset();

      tick();
      tick();
      check_reset_values("reset");
      rst_n = 1'b1;

      // sequential bytes of word0: one miss then three hits
      for (int i = 0; i < 4; i++) fetch(1'b0);
      check("seq_last_byte", next_byte, 8'h60);
      check("seq_pc", pc, 4);

      // word crossing with an ignored start during MEM_REQ
      fetch(1'b1);
      check("cross_byte", next_byte, 8'hAC);
      check("cross_pc", pc, 5);

      // branch into the cached word
      load(7, 1'b0);
      fetch(1'b0);
      check("branch_byte", next_byte, 8'h00);
      check("branch_pc", pc, 8);

      // abort in MEM_WAIT, then word0 is read again
      do_pc_reset(1'b0);
      abort(1'b1, 1'b0, 0);
      fetch(1'b0);
      check("reread_byte", next_byte, 8'hC4);

      // out-of-range load folds, then PC wraps past the last byte
      load(31, 1'b1);
      check("fold_pc", pc, 15);
      fetch(1'b0);
      check("wrap_byte", next_byte, 8'hB1);
      check("wrap_pc", pc, 0);

      // cache word0, then reset during a word1 fetch: word0 must be re-read
      fetch(1'b0);
      load(4, 1'b0);
      reset_mid_fetch();
      fetch(1'b0);

      for (int it = 0; it < 200; it++) begin
         int r;
         r = $urandom_range(0, 9);
         case (r)
            0: ram[$urandom_range(0, SIZE - 1)] = $urandom;
            1: load($urandom_range(0, 2 * SPAN - 1), 1'($urandom_range(0, 1)));
            2: do_pc_reset(1'($urandom_range(0, 1)));
            3: begin
               if (!model_hit())
                  abort(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 2 * SPAN - 1));
               else
                  fetch(1'b0);
            end
            4: begin
               if (!model_hit() && $urandom_range(0, 3) == 0) reset_mid_fetch();
               else fetch(1'($urandom_range(0, 1)));
            end
            default: fetch(1'($urandom_range(0, 1)));
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
